// File: rtl/demux12_stream_if.sv
// Handshake bundle for demux12_stream: one input word stream and two output lanes.
// master = producer/consumer side (testbench or surrounding logic), slave = the demux.
interface demux12_stream_if #(
    parameter int unsigned WIDTH = 72
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux12_stream.sv
// Registered 1:2 stream demux: each word is steered by in_sel into a per-lane DEPTH-entry FIFO.
// Optional macro DEMUX12_BEAT_CNT_EN adds 16-bit per-lane pop counters beat_cnt0/beat_cnt1.
module demux12_stream #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    demux12_stream_if.slave bus
`ifdef DEMUX12_BEAT_CNT_EN
    ,
    output logic [15:0]     beat_cnt0,
    output logic [15:0]     beat_cnt1
`endif
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem    [2][DEPTH];
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [CW-1:0]    count  [2];
    logic [WIDTH-1:0] hold   [2];
    logic [WIDTH-1:0] head   [2];
    logic [1:0]       full;
    logic [1:0]       valid;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             in_rdy;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            full[l]  = (count[l] == CW'(DEPTH));
            valid[l] = (count[l] != '0);
            // An empty lane keeps showing the last head it presented.
            head[l]  = valid[l] ? mem[l][rd_ptr[l]] : hold[l];
        end
        // Ready looks only at the selected lane's occupancy: no ready-to-ready path.
        in_rdy  = ~full[bus.in_sel];
        push[0] = bus.in_valid & in_rdy & ~bus.in_sel;
        push[1] = bus.in_valid & in_rdy & bus.in_sel;
        pop[0]  = valid[0] & bus.out0_ready;
        pop[1]  = valid[1] & bus.out1_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                count[l]  <= '0;
                hold[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push[l]) wr_ptr[l] <= wr_ptr[l] + 1'b1;
                if (pop[l])  rd_ptr[l] <= rd_ptr[l] + 1'b1;
                if (push[l] && !pop[l]) begin
                    count[l] <= count[l] + 1'b1;
                end else if (pop[l] && !push[l]) begin
                    count[l] <= count[l] - 1'b1;
                end
                hold[l] <= head[l];
            end
        end
    end

    // Storage needs no reset: an empty lane never exposes it.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) mem[l][wr_ptr[l]] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out0_valid = valid[0];
    assign bus.out0_data  = head[0];
    assign bus.out1_valid = valid[1];
    assign bus.out1_data  = head[1];

`ifdef DEMUX12_BEAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt0 <= 16'd0;
            beat_cnt1 <= 16'd0;
        end else begin
            if (pop[0]) beat_cnt0 <= beat_cnt0 + 16'd1;
            if (pop[1]) beat_cnt1 <= beat_cnt1 + 16'd1;
        end
    end
`endif
endmodule
